// File: rtl/hesap_pkg.sv
// Shared widths, operation/status codes, FSM states and the command payload
// used by the calculator initiator.
package hesap_pkg;

  localparam int unsigned SAYI_W  = 32;
  localparam int unsigned SONUC_W = 64;
  localparam int unsigned TUR_W   = 3;
  localparam int unsigned DURUM_W = 2;
  localparam int unsigned KOMUT_W = TUR_W + 2 * SAYI_W;

  localparam logic [TUR_W-1:0] TUR_TOPLA    = 3'b000;
  localparam logic [TUR_W-1:0] TUR_CIKAR    = 3'b001;
  localparam logic [TUR_W-1:0] TUR_CARP     = 3'b010;
  localparam logic [TUR_W-1:0] TUR_BOL      = 3'b011;
  localparam logic [TUR_W-1:0] TUR_KOK      = 3'b100;
  localparam logic [TUR_W-1:0] TUR_TAN      = 3'b101;
  localparam logic [TUR_W-1:0] TUR_COT      = 3'b110;
  localparam logic [TUR_W-1:0] TUR_GECERSIZ = 3'b111;

  localparam logic [DURUM_W-1:0] DURUM_TAMAM    = 2'b00;
  localparam logic [DURUM_W-1:0] DURUM_TASMA    = 2'b01;
  localparam logic [DURUM_W-1:0] DURUM_GECERSIZ = 2'b10;
  localparam logic [DURUM_W-1:0] DURUM_ZAMAN    = 2'b11;

  typedef enum logic [1:0] {
    BOS    = 2'd0,
    GONDER = 2'd1,
    BEKLE  = 2'd2,
    CEVAP  = 2'd3
  } fsm_e;

  typedef struct packed {
    logic [TUR_W-1:0]  tur;
    logic [SAYI_W-1:0] sayi2;
    logic [SAYI_W-1:0] sayi1;
  } komut_t;

endpackage

// File: rtl/komut_fifo.sv
// Synchronous command FIFO with registered occupancy; a pushed entry becomes
// visible at the read port only from the following cycle.
module komut_fifo #(
  parameter int unsigned DERINLIK = 4,
  parameter int unsigned GENISLIK = 67
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [GENISLIK-1:0]       veri_i,
  input  logic                      pop_i,
  output logic [GENISLIK-1:0]       veri_o,
  output logic                      dolu_o,
  output logic                      bos_o,
  output logic [$clog2(DERINLIK):0] sayi_o
);

  localparam int unsigned PTR_W = $clog2(DERINLIK);
  localparam logic [PTR_W:0] TAM = (PTR_W + 1)'(DERINLIK);

  logic [GENISLIK-1:0] mem_q [DERINLIK];
  logic [PTR_W-1:0]    yaz_q;
  logic [PTR_W-1:0]    oku_q;
  logic [PTR_W:0]      sayi_q;
  logic                yaz;
  logic                oku;

  assign yaz    = push_i && !dolu_o;
  assign oku    = pop_i && !bos_o;
  assign dolu_o = (sayi_q == TAM);
  assign bos_o  = (sayi_q == '0);
  assign veri_o = mem_q[oku_q];
  assign sayi_o = sayi_q;

  always_ff @(posedge clk) begin
    if (yaz) mem_q[yaz_q] <= veri_i;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      yaz_q  <= '0;
      oku_q  <= '0;
      sayi_q <= '0;
    end else begin
      if (yaz) yaz_q <= yaz_q + PTR_W'(1);
      if (oku) oku_q <= oku_q + PTR_W'(1);
      case ({yaz, oku})
        2'b10:   sayi_q <= sayi_q + (PTR_W + 1)'(1);
        2'b01:   sayi_q <= sayi_q - (PTR_W + 1)'(1);
        default: sayi_q <= sayi_q;
      endcase
    end
  end

endmodule

// File: rtl/hesap_istemci.sv
// Calculator initiator: buffers commands, issues one at a time, returns tagged
// results. Define HESAP_ZAMAN_ASIMI_EN to bound the wait for the calculator.
module hesap_istemci
  import hesap_pkg::*;
#(
  parameter int unsigned KUYRUK_DERINLIK = 4,
  parameter int unsigned ETIKET_W        = 4,
  parameter int unsigned YERLESME        = 2,
  parameter int unsigned ZAMAN_ASIMI     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                komut_gecerli,
  output logic                komut_hazir,
  input  logic [SAYI_W-1:0]   komut_sayi1,
  input  logic [SAYI_W-1:0]   komut_sayi2,
  input  logic [TUR_W-1:0]    komut_tur,
  output logic [SAYI_W-1:0]   sayi1,
  output logic [SAYI_W-1:0]   sayi2,
  output logic [TUR_W-1:0]    tur,
  output logic                istek,
  input  logic [SONUC_W-1:0]  hesap_sonuc,
  input  logic                hesap_hazir,
  input  logic                hesap_gecerli,
  input  logic                hesap_tasma,
  output logic                cevap_gecerli,
  input  logic                cevap_hazir,
  output logic [SONUC_W-1:0]  cevap_sonuc,
  output logic [DURUM_W-1:0]  cevap_durum,
  output logic [ETIKET_W-1:0] cevap_etiket,
  output logic                mesgul
);

  localparam int unsigned SAYAC_UST = (ZAMAN_ASIMI > YERLESME) ? ZAMAN_ASIMI : YERLESME;
  localparam int unsigned SAYAC_W   = $clog2(SAYAC_UST + 1);
  localparam logic [SAYAC_W-1:0] YERLESME_C = SAYAC_W'(YERLESME);
`ifdef HESAP_ZAMAN_ASIMI_EN
  localparam logic [SAYAC_W-1:0] ZAMAN_C = SAYAC_W'(ZAMAN_ASIMI);
`endif

  komut_t                       giris;
  komut_t                       bas;
  logic                         fifo_dolu;
  logic                         fifo_bos;
  logic [$clog2(KUYRUK_DERINLIK):0] fifo_sayi;
  logic                         pop;

  fsm_e                durum_q, durum_d;
  logic [SAYI_W-1:0]   sayi1_q, sayi1_d;
  logic [SAYI_W-1:0]   sayi2_q, sayi2_d;
  logic [TUR_W-1:0]    tur_q, tur_d;
  logic                istek_q, istek_d;
  logic [SAYAC_W-1:0]  sayac_q, sayac_d;
  logic [ETIKET_W-1:0] etiket_sayac_q, etiket_sayac_d;
  logic [ETIKET_W-1:0] cevap_etiket_q, cevap_etiket_d;
  logic [SONUC_W-1:0]  cevap_sonuc_q, cevap_sonuc_d;
  logic [DURUM_W-1:0]  cevap_durum_q, cevap_durum_d;
  logic                cevap_gecerli_q, cevap_gecerli_d;

  assign giris = '{tur: komut_tur, sayi2: komut_sayi2, sayi1: komut_sayi1};

  komut_fifo #(
    .DERINLIK(KUYRUK_DERINLIK),
    .GENISLIK(KOMUT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (komut_gecerli),
    .veri_i (giris),
    .pop_i  (pop),
    .veri_o (bas),
    .dolu_o (fifo_dolu),
    .bos_o  (fifo_bos),
    .sayi_o (fifo_sayi)
  );

  assign komut_hazir   = !fifo_dolu;
  assign mesgul        = (durum_q != BOS) || (fifo_sayi != '0);
  assign sayi1         = sayi1_q;
  assign sayi2         = sayi2_q;
  assign tur           = tur_q;
  assign istek         = istek_q;
  assign cevap_gecerli = cevap_gecerli_q;
  assign cevap_sonuc   = cevap_sonuc_q;
  assign cevap_durum   = cevap_durum_q;
  assign cevap_etiket  = cevap_etiket_q;

  always_comb begin
    durum_d         = durum_q;
    sayi1_d         = sayi1_q;
    sayi2_d         = sayi2_q;
    tur_d           = tur_q;
    istek_d         = 1'b0;
    sayac_d         = sayac_q;
    etiket_sayac_d  = etiket_sayac_q;
    cevap_etiket_d  = cevap_etiket_q;
    cevap_sonuc_d   = cevap_sonuc_q;
    cevap_durum_d   = cevap_durum_q;
    cevap_gecerli_d = cevap_gecerli_q;
    pop             = 1'b0;

    case (durum_q)
      BOS: begin
        if (!fifo_bos) begin
          pop            = 1'b1;
          cevap_etiket_d = etiket_sayac_q;
          etiket_sayac_d = etiket_sayac_q + ETIKET_W'(1);
          // Invalid opcodes are answered locally and never reach the calculator.
          if (bas.tur == TUR_GECERSIZ) begin
            cevap_durum_d   = DURUM_GECERSIZ;
            cevap_sonuc_d   = '0;
            cevap_gecerli_d = 1'b1;
            durum_d         = CEVAP;
          end else begin
            sayi1_d = bas.sayi1;
            sayi2_d = bas.sayi2;
            tur_d   = bas.tur;
            istek_d = 1'b1;
            durum_d = GONDER;
          end
        end
      end
      GONDER: begin
        sayac_d = SAYAC_W'(1);
        durum_d = BEKLE;
      end
      BEKLE: begin
        if ((sayac_q >= YERLESME_C) && hesap_hazir) begin
          cevap_sonuc_d   = hesap_sonuc;
          cevap_gecerli_d = 1'b1;
          durum_d         = CEVAP;
          if (!hesap_gecerli)   cevap_durum_d = DURUM_GECERSIZ;
          else if (hesap_tasma) cevap_durum_d = DURUM_TASMA;
          else                  cevap_durum_d = DURUM_TAMAM;
        end
`ifdef HESAP_ZAMAN_ASIMI_EN
        else if (sayac_q >= ZAMAN_C) begin
          cevap_sonuc_d   = '0;
          cevap_durum_d   = DURUM_ZAMAN;
          cevap_gecerli_d = 1'b1;
          durum_d         = CEVAP;
        end else begin
          sayac_d = sayac_q + SAYAC_W'(1);
        end
`else
        else if (sayac_q < YERLESME_C) begin
          sayac_d = sayac_q + SAYAC_W'(1);
        end
`endif
      end
      CEVAP: begin
        if (cevap_hazir) begin
          cevap_gecerli_d = 1'b0;
          durum_d         = BOS;
        end
      end
      default: durum_d = BOS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q         <= BOS;
      sayi1_q         <= '0;
      sayi2_q         <= '0;
      tur_q           <= '0;
      istek_q         <= 1'b0;
      sayac_q         <= '0;
      etiket_sayac_q  <= '0;
      cevap_etiket_q  <= '0;
      cevap_sonuc_q   <= '0;
      cevap_durum_q   <= '0;
      cevap_gecerli_q <= 1'b0;
    end else begin
      durum_q         <= durum_d;
      sayi1_q         <= sayi1_d;
      sayi2_q         <= sayi2_d;
      tur_q           <= tur_d;
      istek_q         <= istek_d;
      sayac_q         <= sayac_d;
      etiket_sayac_q  <= etiket_sayac_d;
      cevap_etiket_q  <= cevap_etiket_d;
      cevap_sonuc_q   <= cevap_sonuc_d;
      cevap_durum_q   <= cevap_durum_d;
      cevap_gecerli_q <= cevap_gecerli_d;
    end
  end

endmodule

// File: tb/tb_hesap_istemci.sv
// Bench for hesap_istemci: timestamp-based transaction model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_hesap_istemci;

  localparam int unsigned D  = 4;
  localparam int unsigned EW = 4;
  localparam int unsigned Y  = 2;
  localparam int unsigned Z  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          komut_gecerli;
  logic          komut_hazir;
  logic [31:0]   komut_sayi1;
  logic [31:0]   komut_sayi2;
  logic [2:0]    komut_tur;
  logic [31:0]   sayi1;
  logic [31:0]   sayi2;
  logic [2:0]    tur;
  logic          istek;
  logic [63:0]   hesap_sonuc;
  logic          hesap_hazir;
  logic          hesap_gecerli;
  logic          hesap_tasma;
  logic          cevap_gecerli;
  logic          cevap_hazir;
  logic [63:0]   cevap_sonuc;
  logic [1:0]    cevap_durum;
  logic [EW-1:0] cevap_etiket;
  logic          mesgul;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  always #5 clk = ~clk;

  hesap_istemci #(
    .KUYRUK_DERINLIK(D),
    .ETIKET_W(EW),
    .YERLESME(Y),
    .ZAMAN_ASIMI(Z)
  ) dut (
    .clk(clk), .rst(rst),
    .komut_gecerli(komut_gecerli), .komut_hazir(komut_hazir),
    .komut_sayi1(komut_sayi1), .komut_sayi2(komut_sayi2), .komut_tur(komut_tur),
    .sayi1(sayi1), .sayi2(sayi2), .tur(tur), .istek(istek),
    .hesap_sonuc(hesap_sonuc), .hesap_hazir(hesap_hazir),
    .hesap_gecerli(hesap_gecerli), .hesap_tasma(hesap_tasma),
    .cevap_gecerli(cevap_gecerli), .cevap_hazir(cevap_hazir),
    .cevap_sonuc(cevap_sonuc), .cevap_durum(cevap_durum),
    .cevap_etiket(cevap_etiket), .mesgul(mesgul)
  );

  // Calculator stub: result is a fixed function of the presented operands.
  function automatic logic [63:0] calc(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] t);
    case (t)
      3'd0:    calc = 64'(a) + 64'(b);
      3'd1:    calc = 64'(a) - 64'(b);
      3'd2:    calc = 64'(a) * 64'(b);
      default: calc = {a ^ b, 29'd0, t};
    endcase
  endfunction

  assign hesap_sonuc = calc(sayi1, sayi2, tur);

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h cycle=%0d", nm, a, e, n);
    end
  endtask

  // ---------------- reference model (timestamps, not states) ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  t;
  } cmd_t;

  cmd_t          mq[$];
  bit            m_init = 0;
  bit            m_op   = 0;   // an operation popped and not yet accepted
  bit            m_rv   = 0;   // its response is being presented
  bit            m_istek = 0;
  int            m_pop  = 0;   // edge index at which the current op was popped
  cmd_t          m_cur;
  logic [63:0]   m_sonuc;
  logic [1:0]    m_durum;
  logic [EW-1:0] m_etk;
  logic [EW-1:0] m_tag;

  always @(posedge clk) begin
    bit hz;
    n++;
    m_istek = 0;
    if (rst) begin
      mq.delete();
      m_op = 0; m_rv = 0; m_tag = '0; m_init = 1;
    end else begin
      hz = (mq.size() < D);
      if (m_op) begin
        if (m_rv) begin
          if (cevap_hazir) begin m_op = 0; m_rv = 0; end
        end else if (n >= m_pop + 1 + int'(Y) && hesap_hazir) begin
          m_rv = 1;
          m_sonuc = calc(m_cur.a, m_cur.b, m_cur.t);
          m_durum = !hesap_gecerli ? 2'b10 : (hesap_tasma ? 2'b01 : 2'b00);
        end
`ifdef HESAP_ZAMAN_ASIMI_EN
        else if (n == m_pop + 1 + int'(Z)) begin
          m_rv = 1; m_sonuc = '0; m_durum = 2'b11;
        end
`endif
      end else if (mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_op  = 1;
        m_pop = n;
        m_etk = m_tag;
        m_tag = m_tag + EW'(1);
        if (m_cur.t == 3'b111) begin
          m_rv = 1; m_sonuc = '0; m_durum = 2'b10;
        end else begin
          m_istek = 1;
        end
      end
      if (komut_gecerli && hz) mq.push_back('{a: komut_sayi1, b: komut_sayi2, t: komut_tur});
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("komut_hazir", 64'(komut_hazir), 64'(mq.size() < D));
      chk("istek", 64'(istek), 64'(m_istek));
      chk("cevap_gecerli", 64'(cevap_gecerli), 64'(m_rv));
      chk("mesgul", 64'(mesgul), 64'(m_op || mq.size() > 0));
      if (m_rv) begin
        chk("cevap_sonuc", cevap_sonuc, m_sonuc);
        chk("cevap_durum", 64'(cevap_durum), 64'(m_durum));
        chk("cevap_etiket", 64'(cevap_etiket), 64'(m_etk));
      end
      if (m_op && !m_rv) begin
        chk("sayi1", 64'(sayi1), 64'(m_cur.a));
        chk("sayi2", 64'(sayi2), 64'(m_cur.b));
        chk("tur", 64'(tur), 64'(m_cur.t));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_zero(input string nm);
    @(negedge clk);
    chk({nm, "_istek"}, 64'(istek), 64'd0);
    chk({nm, "_cv"}, 64'(cevap_gecerli), 64'd0);
    chk({nm, "_sonuc"}, cevap_sonuc, 64'd0);
    chk({nm, "_durum"}, 64'(cevap_durum), 64'd0);
    chk({nm, "_etiket"}, 64'(cevap_etiket), 64'd0);
    chk({nm, "_sayi1"}, 64'(sayi1), 64'd0);
    chk({nm, "_sayi2"}, 64'(sayi2), 64'd0);
    chk({nm, "_tur"}, 64'(tur), 64'd0);
    chk({nm, "_mesgul"}, 64'(mesgul), 64'd0);
    chk({nm, "_khazir"}, 64'(komut_hazir), 64'd1);
  endtask

  // Push one command in cycle 0 and log istek/response timing relative to it.
  task automatic push_log(input logic [31:0] a, input logic [31:0] b, input logic [2:0] t,
                          input int ncyc, input int hz_pulse_at,
                          output int f_istek, output int n_istek, output int f_cv,
                          output logic [63:0] s, output logic [1:0] d,
                          output logic [EW-1:0] e);
    komut_sayi1 = a; komut_sayi2 = b; komut_tur = t; komut_gecerli = 1'b1;
    f_istek = -1; n_istek = 0; f_cv = -1; s = '0; d = '0; e = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (hz_pulse_at >= 0) hesap_hazir = (k == hz_pulse_at);
      @(negedge clk);
      if (istek) begin
        n_istek++;
        if (f_istek < 0) f_istek = k;
      end
      if (cevap_gecerli && f_cv < 0) begin
        f_cv = k; s = cevap_sonuc; d = cevap_durum; e = cevap_etiket;
      end
      tick();
      komut_gecerli = 1'b0;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    @(negedge clk);
    while (mesgul && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("idle_budget", 64'(mesgul), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=running want=finished cycle=%0d", n);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int fi, ni, fc;
    logic [63:0] s;
    logic [1:0] d;
    logic [EW-1:0] e;
    logic [EW-1:0] got_e[$];
    logic [63:0] got_s[$];

    rst = 1'b1; komut_gecerli = 1'b0; komut_sayi1 = '0; komut_sayi2 = '0; komut_tur = '0;
    hesap_hazir = 1'b1; hesap_gecerli = 1'b1; hesap_tasma = 1'b0; cevap_hazir = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_zero("reset");
    tick();

    // Single add: istek at 2, response at 5.
    push_log(32'd5, 32'd7, 3'b000, 12, -1, fi, ni, fc, s, d, e);
    chk("add_istek_cyc", 64'(fi), 64'd2);
    chk("add_istek_cnt", 64'(ni), 64'd1);
    chk("add_cv_cyc", 64'(fc), 64'd5);
    chk("add_sonuc", s, 64'd12);
    chk("add_durum", 64'(d), 64'd0);
    chk("add_etiket", 64'(e), 64'd0);

    // Invalid opcode: answered one cycle after the pop, never issued.
    push_log(32'd9, 32'd9, 3'b111, 12, -1, fi, ni, fc, s, d, e);
    chk("inv_istek_cnt", 64'(ni), 64'd0);
    chk("inv_cv_cyc", 64'(fc), 64'd2);
    chk("inv_durum", 64'(d), 64'd2);
    chk("inv_sonuc", s, 64'd0);
    chk("inv_etiket", 64'(e), 64'd1);

    // Status priority: invalid beats overflow, then overflow alone.
    hesap_gecerli = 1'b0; hesap_tasma = 1'b1;
    push_log(32'd1, 32'd2, 3'b000, 12, -1, fi, ni, fc, s, d, e);
    chk("pri_inv_durum", 64'(d), 64'd2);
    chk("pri_inv_etiket", 64'(e), 64'd2);
    hesap_gecerli = 1'b1;
    push_log(32'd1, 32'd2, 3'b000, 12, -1, fi, ni, fc, s, d, e);
    chk("pri_ovf_durum", 64'(d), 64'd1);
    chk("pri_ovf_sonuc", s, 64'd3);
    hesap_tasma = 1'b0;

    // Early hazir only in the first BEKLE cycle must be ignored.
`ifdef HESAP_ZAMAN_ASIMI_EN
    push_log(32'd4, 32'd4, 3'b001, 20, 3, fi, ni, fc, s, d, e);
    chk("to_cv_cyc", 64'(fc), 64'd11);
    chk("to_durum", 64'(d), 64'd3);
    chk("to_sonuc", s, 64'd0);
    chk("to_etiket", 64'(e), 64'd4);
    hesap_hazir = 1'b1;
`else
    push_log(32'd4, 32'd4, 3'b001, 100, 3, fi, ni, fc, s, d, e);
    chk("noto_cv_cyc", 64'(fc), 64'hFFFF_FFFF_FFFF_FFFF);
    hesap_hazir = 1'b1;
    wait_idle(20);
`endif

    // Backpressure: five commands, response held, then drained in order.
    rst = 1'b1; tick(); rst = 1'b0;
    cevap_hazir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      komut_gecerli = 1'b1; komut_sayi1 = 32'(i + 1); komut_sayi2 = 32'd100; komut_tur = 3'b000;
      @(negedge clk);
      chk("bp_hazir_open", 64'(komut_hazir), 64'd1);
      tick();
    end
    komut_gecerli = 1'b0;
    @(negedge clk);
    chk("bp_full", 64'(komut_hazir), 64'd0);
    tick();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k % 5 == 0) begin
        chk("bp_hold_cv", 64'(cevap_gecerli), 64'd1);
        chk("bp_hold_etiket", 64'(cevap_etiket), 64'd0);
        chk("bp_hold_sonuc", cevap_sonuc, 64'd101);
        chk("bp_hold_full", 64'(komut_hazir), 64'd0);
      end
      tick();
    end
    cevap_hazir = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (cevap_gecerli) begin
        got_e.push_back(cevap_etiket);
        got_s.push_back(cevap_sonuc);
      end
      tick();
    end
    chk("bp_drain_count", 64'(got_e.size()), 64'd5);
    for (int i = 0; i < got_e.size(); i++) begin
      chk("bp_drain_etiket", 64'(got_e[i]), 64'(i));
      chk("bp_drain_sonuc", got_s[i], 64'(i + 101));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      komut_gecerli = ($urandom_range(0, 9) < 4);
      komut_sayi1   = $urandom;
      komut_sayi2   = $urandom;
      komut_tur     = 3'($urandom_range(0, 7));
      hesap_hazir   = ($urandom_range(0, 9) < 6);
      hesap_gecerli = ($urandom_range(0, 9) < 9);
      hesap_tasma   = ($urandom_range(0, 9) < 2);
      cevap_hazir   = ($urandom_range(0, 9) < 6);
      tick();
    end
    komut_gecerli = 1'b0; hesap_hazir = 1'b1; hesap_gecerli = 1'b1;
    hesap_tasma = 1'b0; cevap_hazir = 1'b1;
    wait_idle(100);

    // Reset while waiting in BEKLE abandons the operation.
    hesap_hazir = 1'b0;
    komut_gecerli = 1'b1; komut_sayi1 = 32'd3; komut_sayi2 = 32'd4; komut_tur = 3'b000;
    tick();
    komut_gecerli = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hesap_hazir = 1'b1;
    chk_reset_zero("midrst");
    tick();
    push_log(32'd2, 32'd2, 3'b000, 12, -1, fi, ni, fc, s, d, e);
    chk("midrst_etiket", 64'(e), 64'd0);
    chk("midrst_sonuc", s, 64'd4);
    chk("midrst_cv_cyc", 64'(fc), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
